// File: rtl/ram_nr1w_clr.sv
// Multi-read, single byte-masked write register array with a self-clearing sweep after reset or clr_req.
// Optional macro RAM_NR1W_WR_BYPASS_EN forwards a same-cycle write to matching read ports.
module ram_nr1w_clr #(
    parameter int               WIDTH     = 32,
    parameter int               LG_DEPTH  = 6,
    parameter int               NUM_RD    = 2,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*LG_DEPTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    input  logic                       wr_en,
    input  logic [LG_DEPTH-1:0]        wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [WIDTH/8-1:0]         wr_mask,
    input  logic                       clr_req,
    output logic                       ready
);

    localparam int DEPTH  = 1 << LG_DEPTH;
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [LG_DEPTH-1:0] clr_ptr;
    logic [LG_DEPTH-1:0] clr_ptr_next;
    logic                wr_accept;
    logic [WIDTH-1:0]    mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // A clr_req in either state restarts the sweep from entry 0.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            CLEAR: begin
                if (clr_req) begin
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (clr_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    always_comb begin
        ready     = (state == READY);
        wr_accept = wr_en & (state == READY);
    end

    // Storage is deliberately left unreset; the sweep owns initialisation.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_ptr] <= CLR_VALUE;
        end else if (wr_accept) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

`ifdef RAM_NR1W_WR_BYPASS_EN
    logic [WIDTH-1:0] wr_merged;

    always_comb begin
        wr_merged = mem[wr_addr];
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_mask[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (!ready) begin
                    rd_data[i*WIDTH +: WIDTH] <= '0;
                end else begin
`ifdef RAM_NR1W_WR_BYPASS_EN
                    if (wr_en && (rd_addr[i*LG_DEPTH +: LG_DEPTH] == wr_addr)) begin
                        rd_data[i*WIDTH +: WIDTH] <= wr_merged;
                    end else begin
                        rd_data[i*WIDTH +: WIDTH] <= mem[rd_addr[i*LG_DEPTH +: LG_DEPTH]];
                    end
`else
                    rd_data[i*WIDTH +: WIDTH] <= mem[rd_addr[i*LG_DEPTH +: LG_DEPTH]];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_nr1w_clr.sv
// Scoreboard bench for ram_nr1w_clr: directed windows queue expected outputs, a negedge monitor compares them.
module tb_ram_nr1w_clr;

    localparam int WIDTH    = 32;
    localparam int LG_DEPTH = 4;
    localparam int NUM_RD   = 2;
    localparam int DEPTH    = 16;

`ifdef RAM_NR1W_WR_BYPASS_EN
    localparam logic [31:0] COLL_FULL = 32'hDEADBEEF;
    localparam logic [31:0] COLL_PART = 32'hDEAD0000;
`else
    localparam logic [31:0] COLL_FULL = 32'h00000000;
    localparam logic [31:0] COLL_PART = 32'hDEADBEEF;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_RD*LG_DEPTH-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]    rd_data;
    logic                       wr_en;
    logic [LG_DEPTH-1:0]        wr_addr;
    logic [WIDTH-1:0]           wr_data;
    logic [WIDTH/8-1:0]         wr_mask;
    logic                       clr_req;
    logic                       ready;

    always #5 clk = ~clk;

    ram_nr1w_clr #(
        .WIDTH    (WIDTH),
        .LG_DEPTH (LG_DEPTH),
        .NUM_RD   (NUM_RD),
        .CLR_VALUE(32'h0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .clr_req(clr_req),
        .ready  (ready)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    n_compared = 0;
    int    n_mismatched = 0;
    string kind_name[3] = '{"ready", "rd0", "rd1"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] actualOf(input int kind);
        if (kind == 0) return {31'b0, ready};
        if (kind == 1) return rd_data[31:0];
        return rd_data[63:32];
    endfunction

    // Monitor: everything due by this cycle is compared once registered outputs have settled.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("%s@%0d", kind_name[e.kind], e.cyc), actualOf(e.kind), e.val);
        end
    end

    task automatic expectAfter(input int kind, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] wm, input logic cr,
                                 input logic [3:0] ra0, input logic [3:0] ra1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        clr_req = cr;
        rd_addr = {ra1, ra0};
    endtask

    task automatic expectSweep();
        for (int k = 0; k < DEPTH; k++) begin
            expectAfter(0, (k == DEPTH - 1) ? 32'd1 : 32'd0);
            expectAfter(1, 32'd0);
            expectAfter(2, 32'd0);
            nextCycle();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();

        expectAfter(0, 0);
        expectAfter(1, 0);
        expectAfter(2, 0);
        nextCycle();

        // Initial sweep: ready rises on the 16th edge after deassertion.
        reset = 1'b0;
        expectSweep();
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'(a), 4'(15 - a));
            expectAfter(0, 1);
            expectAfter(1, 0);
            expectAfter(2, 0);
            nextCycle();
        end

        // Byte mask merge.
        applyStimulus(1, 5, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 5, 32'h11223344, 4'b0101, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5, 5);
        expectAfter(1, 32'hAA22CC44);
        expectAfter(2, 32'hAA22CC44);
        nextCycle();

        // Zero mask is a no-op, including for a same-cycle read.
        applyStimulus(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 5, 5);
        expectAfter(1, 32'hAA22CC44);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        expectAfter(1, 32'hAA22CC44);
        nextCycle();

        // Write/read collision, full and partial mask.
        applyStimulus(1, 3, 32'hDEADBEEF, 4'b1111, 0, 3, 4);
        expectAfter(1, COLL_FULL);
        expectAfter(2, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 3, 3);
        expectAfter(1, 32'hDEADBEEF);
        expectAfter(2, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1, 3, 32'h00000000, 4'b0011, 0, 3, 5);
        expectAfter(1, COLL_PART);
        expectAfter(2, 32'hAA22CC44);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 3, 3);
        expectAfter(1, 32'hDEAD0000);
        nextCycle();

        // Fill, then clear on request with writes attempted mid-sweep.
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1, 4'(a), 32'h55555555, 4'b1111, 0, 0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        expectAfter(0, 0);
        expectAfter(1, 32'h55555555);
        expectAfter(2, 32'h55555555);
        nextCycle();
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus((k == 0 || k == 14), 2, 32'h77, 4'b1111, 0, 2, 4'(k));
            expectAfter(0, (k == DEPTH - 1) ? 32'd1 : 32'd0);
            expectAfter(1, 0);
            expectAfter(2, 0);
            nextCycle();
        end
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(0, 0, 0, 0, 0, 4'(a), 4'(a));
            expectAfter(1, 0);
            expectAfter(2, 0);
            nextCycle();
        end

        // Restart: second pulse at sweep index 9.
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        expectAfter(0, 0);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0, (k == 9), 0, 0);
            expectAfter(0, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        expectSweep();

        // Asynchronous reset while rd_data is nonzero.
        applyStimulus(1, 7, 32'h12345678, 4'b1111, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 7, 7);
        expectAfter(1, 32'h12345678);
        expectAfter(2, 32'h12345678);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("async_ready", {31'b0, ready}, 32'd0);
        checkOutput("async_rd0", rd_data[31:0], 32'd0);
        checkOutput("async_rd1", rd_data[63:32], 32'd0);
        nextCycle();
        reset = 1'b0;
        expectSweep();
        applyStimulus(0, 0, 0, 0, 0, 7, 5);
        expectAfter(1, 0);
        expectAfter(2, 0);
        nextCycle();

        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            nextCycle();
        end
        if (sb.size() > 0) begin
            checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
